// File: rtl/elastic_pipeline_sv.sv
// elastic_pipeline_sv
//   Valid/ready elastic pipeline made of STAGES register slices. Backpressure
//   travels upstream one slice per cycle. Each slice is a 2-entry skid buffer,
//   so In_ready comes from a register and has no combinational path from
//   Out_ready. Words leave in the order they arrived, at up to 1 word/cycle.
//
// Parameters
//   WORD_LENGTH  data width (>= 1)
//   STAGES       number of slices (>= 1); capacity is 2*STAGES words
//
// Ports
//   Clock      in   system clock
//   Reset      in   synchronous, active-high; empties every slice
//   In_data    in   upstream data
//   In_valid   in   upstream word present
//   In_ready   out  block accepts In_data this cycle
//   Out_data   out  downstream data, held while Out_valid & !Out_ready
//   Out_valid  out  Out_data holds a valid word
//   Out_ready  in   downstream accepts this cycle
//   Occupancy  out  words held (present only when ELASTIC_PIPE_OCCUPANCY_EN is defined)
//
// Build option
//   ELASTIC_PIPE_OCCUPANCY_EN  adds the registered Occupancy counter and port.

module elastic_pipeline_sv #(
  parameter int WORD_LENGTH = 8,
  parameter int STAGES      = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [WORD_LENGTH-1:0] In_data,
  input  logic                   In_valid,
  output logic                   In_ready,
  output logic [WORD_LENGTH-1:0] Out_data,
  output logic                   Out_valid,
  input  logic                   Out_ready
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] Occupancy
`endif
);

  if (WORD_LENGTH < 1) begin : g_bad_width
    $error("elastic_pipeline_sv: WORD_LENGTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("elastic_pipeline_sv: STAGES must be >= 1");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} slice_state_e;

  // Per-slice handshake signals; slice i's downstream side feeds slice i+1.
  logic [STAGES-1:0]      up_valid;
  logic [STAGES-1:0]      up_ready;
  logic [STAGES-1:0]      dn_valid;
  logic [STAGES-1:0]      dn_ready;
  logic [WORD_LENGTH-1:0] up_data [STAGES];
  logic [WORD_LENGTH-1:0] dn_data [STAGES];

  assign up_valid[0]        = In_valid;
  assign up_data[0]         = In_data;
  assign In_ready           = up_ready[0];
  assign Out_valid          = dn_valid[STAGES-1];
  assign Out_data           = dn_data[STAGES-1];
  assign dn_ready[STAGES-1] = Out_ready;

  for (genvar g = 1; g < STAGES; g++) begin : g_chain
    assign up_valid[g]   = dn_valid[g-1];
    assign up_data[g]    = dn_data[g-1];
    assign dn_ready[g-1] = up_ready[g];
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    slice_state_e           state_q, state_d;
    logic [WORD_LENGTH-1:0] main_q, skid_q;
    logic                   in_fire, out_fire;
    logic                   load_main_in, load_main_skid, load_skid;
    logic                   slice_up_ready, slice_dn_valid;

    assign in_fire  = up_valid[i] & up_ready[i];
    assign out_fire = dn_valid[i] & dn_ready[i];

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock) begin
      if (Reset) state_q <= EMPTY;
      else       state_q <= state_d;
    end

    // Next state and register load enables.
    always_comb begin
      // NOTE: every output gets a default first, so no path leaves a
      // variable unassigned and no latch is inferred.
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          // up_ready is low in FULL, so no word can arrive alongside this pop.
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end

    // Outputs are decodes of the state register only.
    always_comb begin
      slice_up_ready = (state_q != FULL);
      slice_dn_valid = (state_q != EMPTY);
    end

    assign up_ready[i] = slice_up_ready;
    assign dn_valid[i] = slice_dn_valid;
    assign dn_data[i]  = main_q;

    // NOTE: data registers are cleared on reset so Out_data reads 0 after
    // reset instead of a stale word.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (load_main_in)        main_q <= up_data[i];
        else if (load_main_skid) main_q <= skid_q;
        if (load_skid)           skid_q <= up_data[i];
      end
    end
  end

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(2*STAGES+1);

  logic top_in_fire, top_out_fire;
  assign top_in_fire  = In_valid & In_ready;
  assign top_out_fire = Out_valid & Out_ready;

  // Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Occupancy <= '0;
    end else begin
      unique case ({top_in_fire, top_out_fire})
        2'b10:   Occupancy <= Occupancy + OCC_W'(1);
        2'b01:   Occupancy <= Occupancy - OCC_W'(1);
        default: Occupancy <= Occupancy;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipeline_sv.sv
// Self-checking bench for elastic_pipeline_sv (STAGES=3, 8-bit words).
// A scoreboard queue receives every accepted word and is popped on every
// output transfer; Occupancy is compared against the queue depth when the
// ELASTIC_PIPE_OCCUPANCY_EN build option is defined.

module tb_elastic_pipeline_sv;
  localparam int W      = 8;
  localparam int STAGES = 3;

  logic         Clock, Reset;
  logic [W-1:0] In_data, Out_data;
  logic         In_valid, In_ready, Out_valid, Out_ready;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
  logic [$clog2(2*STAGES+1)-1:0] Occupancy;
`endif

  elastic_pipeline_sv #(.WORD_LENGTH(W), .STAGES(STAGES)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .In_data  (In_data),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Out_data (Out_data),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready)
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    .Occupancy(Occupancy)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q [$];
  int           cyc = 0;
  int           accepts = 0;
  int           pops = 0;
  int           first_pop_cyc = -1;
  int           last_pop_cyc  = -1;
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: inspect at the falling edge, then return 1 time unit after
  // the rising edge where the caller may change inputs.
  task automatic cycle();
    @(negedge Clock);
    if (!Reset) begin
      if (hold_pending) begin
        check("hold_valid", Out_valid, 1);
        check("hold_data", Out_data, hold_data);
      end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
      check("occupancy", Occupancy, q.size());
`endif
      if (Out_valid && Out_ready) begin
        if (q.size() == 0) check("pop_while_empty", 1, 0);
        else               check("out_data", Out_data, q.pop_front());
        pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (In_valid && In_ready) begin
        q.push_back(In_data);
        accepts++;
      end
      hold_pending = Out_valid && !Out_ready;
      hold_data    = Out_data;
    end else begin
      hold_pending = 1'b0;
    end
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    while (q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_left", q.size(), 0);
    check("drain_out_valid", Out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, pop0, push_cyc, elapsed, sent, guard;
    logic ir;

    // 1: reset held 3 cycles with a word offered.
    Reset = 1'b1; In_valid = 1'b1; In_data = 8'hA5; Out_ready = 1'b1;
    repeat (3) cycle();
    check("t1_out_valid", Out_valid, 0);
    check("t1_out_data", Out_data, 0);
    check("t1_in_ready", In_ready, 1);
    Reset = 1'b0; In_valid = 1'b0;
    repeat (6) cycle();
    check("t1_no_word", Out_valid, 0);
    check("t1_no_pop", pops, 0);

    // 2: back-to-back stream with Out_ready=1.
    first_pop_cyc = -1; pop0 = pops; push_cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      In_valid = 1'b1; In_data = W'(k);
      check("t2_in_ready", In_ready, 1);
      if (k == 1) push_cyc = cyc;
      cycle();
    end
    drain(50);
    check("t2_latency", first_pop_cyc - push_cyc, STAGES);
    check("t2_consecutive", last_pop_cyc - first_pop_cyc, 9);
    check("t2_pops", pops - pop0, 10);

    // 3: fill against a stalled sink, then release.
    Out_ready = 1'b0; acc0 = accepts;
    for (int j = 0; j < 12; j++) begin
      In_valid = 1'b1; In_data = W'(8'h50 + j);
      cycle();
    end
    check("t3_accepted", accepts - acc0, 2*STAGES);
    check("t3_in_ready_low", In_ready, 0);
    Out_ready = 1'b1; elapsed = 0;
    while (!In_ready && elapsed < 20) begin
      cycle();
      elapsed++;
    end
    check("t3_refill_bound", (elapsed <= STAGES) ? 1 : 0, 1);
    for (int j = 0; j < 5; j++) begin
      In_valid = 1'b1; In_data = W'(8'h70 + j);
      cycle();
    end
    drain(60);

    // 4: random valid/ready traffic.
    acc0 = accepts; sent = 0; guard = 0;
    while (sent < 10000 && guard < 50000) begin
      In_valid  = 1'($urandom % 2);
      In_data   = W'($urandom);
      Out_ready = 1'($urandom % 2);
      if (guard % 97 == 0) begin
        ir = In_ready;
        Out_ready = ~Out_ready;
        #1;
        check("no_comb_path", In_ready, ir);
        Out_ready = ~Out_ready;
      end
      cycle();
      guard++;
      sent = accepts - acc0;
    end
    check("t4_sent", (sent >= 10000) ? 1 : 0, 1);
    drain(100);

    // 5: reset while words are held.
    Out_ready = 1'b0; acc0 = accepts;
    for (int k = 0; k < 4; k++) begin
      In_valid = 1'b1; In_data = W'(8'hC0 + k);
      cycle();
    end
    check("t5_held", accepts - acc0, 4);
    Reset = 1'b1; In_valid = 1'b1; In_data = 8'hEE;
    cycle();
    Reset = 1'b0; In_valid = 1'b0;
    q.delete();
    check("t5_out_valid", Out_valid, 0);
    check("t5_in_ready", In_ready, 1);
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    check("t5_occupancy", Occupancy, 0);
`endif
    Out_ready = 1'b1; pop0 = pops;
    for (int k = 0; k < 3; k++) begin
      In_valid = 1'b1; In_data = W'(8'h30 + k);
      cycle();
    end
    drain(40);
    check("t5_pops", pops - pop0, 3);

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    // 6: occupancy under push-only, push+pop, pop-only.
    Out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      In_valid = 1'b1; In_data = W'(8'h90 + k);
      cycle();
    end
    In_valid = 1'b0;
    repeat (3) cycle();
    check("t6_occ_filled", Occupancy, 3);
    for (int k = 0; k < 5; k++) begin
      In_valid = 1'b1; In_data = W'(8'hA0 + k); Out_ready = 1'b1;
      check("t6_both_ready", {Out_valid, In_ready}, 2'b11);
      cycle();
      check("t6_occ_steady", Occupancy, 3);
    end
    drain(40);
    check("t6_occ_empty", Occupancy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
